// File: rtl/imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_port_arbiter
// Description : Shares one single-port memory between the fetch requester
//               (inst_*) and the load/store requester (data_*). One
//               transaction is in flight at a time. Byte addresses are
//               converted to word addresses, the memory request/valid
//               handshake is driven, and the response is returned to the
//               requester that owns the transaction.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               inst_req_i/addr_i   - fetch request (held until inst_valid_o)
//               inst_valid_o/rdata_o- one-cycle completion pulse + data
//               data_req_i/we_i/addr_i/wdata_i - load/store request
//               data_valid_o/rdata_o- one-cycle completion pulse + load data
//               mem_request_o       - one-cycle issue pulse to memory
//               mem_we_o/addr_o/wdata_o - transaction fields, held in WAIT
//               mem_valid_i/rdata_i - memory response strobe + data
//               busy_o              - a transaction is in flight
//               timeout_err_o       - sticky: memory failed to respond
// Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    output logic                  inst_valid_o,
    output logic [DATA_WIDTH-1:0] inst_rdata_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_valid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  mem_request_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o,
    output logic                  timeout_err_o
);

    // Timeout counter sizing; at least one bit even when the timeout is off.
    localparam int c_cnt_w_raw = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_cnt_w     = (c_cnt_w_raw < 1) ? 1 : c_cnt_w_raw;
    localparam bit c_to_en     = (TIMEOUT_CYCLES > 0);
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_to_en ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    localparam logic c_own_inst = 1'b0;
    localparam logic c_own_data = 1'b1;

    logic [1:0]         r_state;
    logic               r_owner;
    logic               r_last_grant;
    logic [c_cnt_w-1:0] r_cnt;

    logic                  w_inst_elig;
    logic                  w_data_elig;
    logic                  w_grant_any;
    logic                  w_grant_data;
    logic                  w_resp_hit;
    logic                  w_timeout;
    logic [DATA_WIDTH-1:0] w_resp_data;
    logic [ADDR_WIDTH-1:0] w_inst_waddr;
    logic [ADDR_WIDTH-1:0] w_data_waddr;

    // Byte-offset bits are dropped by the word conversion.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{inst_addr_i[1:0], data_addr_i[1:0]};

    assign w_inst_waddr = {2'b00, inst_addr_i[ADDR_WIDTH-1:2]};
    assign w_data_waddr = {2'b00, data_addr_i[ADDR_WIDTH-1:2]};

    always_comb begin
        // A requester still showing its completion pulse is holding the
        // request of the transaction that just finished; do not re-grant it.
        w_inst_elig = inst_req_i & ~inst_valid_o;
        w_data_elig = data_req_i & ~data_valid_o;
        w_grant_any = w_inst_elig | w_data_elig;
        if (w_inst_elig && w_data_elig) begin
            w_grant_data = (r_last_grant == c_own_inst);
        end else begin
            w_grant_data = w_data_elig;
        end
    end

    always_comb begin
        // A real response beats a timeout landing in the same cycle.
        w_resp_hit = (r_state == c_st_wait) && mem_valid_i;
        w_timeout  = (r_state == c_st_wait) && !mem_valid_i && c_to_en &&
                     (r_cnt == c_cnt_last);
        // mem_we_o still carries the owner's we; fetches are never stores.
        w_resp_data = (w_resp_hit && !mem_we_o) ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_owner       <= c_own_inst;
            r_last_grant  <= c_own_inst;
            r_cnt         <= '0;
            inst_valid_o  <= 1'b0;
            inst_rdata_o  <= '0;
            data_valid_o  <= 1'b0;
            data_rdata_o  <= '0;
            mem_request_o <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            busy_o        <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            inst_valid_o  <= 1'b0;
            data_valid_o  <= 1'b0;
            mem_request_o <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_grant_any) begin
                        r_owner      <= w_grant_data;
                        r_last_grant <= w_grant_data;
                        if (w_grant_data) begin
                            mem_we_o    <= data_we_i;
                            mem_addr_o  <= w_data_waddr;
                            mem_wdata_o <= data_wdata_i;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= w_inst_waddr;
                            mem_wdata_o <= '0;
                        end
                        // Registered so the pulse coincides with ISSUE.
                        mem_request_o <= 1'b1;
                        busy_o        <= 1'b1;
                        r_state       <= c_st_issue;
                    end
                end

                c_st_issue: begin
                    r_cnt   <= '0;
                    r_state <= c_st_wait;
                end

                c_st_wait: begin
                    if (w_resp_hit || w_timeout) begin
                        if (r_owner == c_own_data) begin
                            data_valid_o <= 1'b1;
                            data_rdata_o <= w_resp_data;
                        end else begin
                            inst_valid_o <= 1'b1;
                            inst_rdata_o <= w_resp_data;
                        end
                        if (w_timeout) begin
                            timeout_err_o <= 1'b1;
                        end
                        busy_o  <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    busy_o  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_dmem_port_arbiter
// Description : Self-checking bench for imem_dmem_port_arbiter. A
//               transaction-level model (who owns the memory, when it was
//               issued, how long it has waited) predicts every output each
//               cycle; directed scenarios add literal expectations, then a
//               randomized phase exercises arbitration, latency, timeout,
//               dropped requests and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_valid;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_valid;
    logic [DW-1:0] data_rdata;
    logic          mem_request;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_valid;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    imem_dmem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req_i    (inst_req),
        .inst_addr_i   (inst_addr),
        .inst_valid_o  (inst_valid),
        .inst_rdata_o  (inst_rdata),
        .data_req_i    (data_req),
        .data_we_i     (data_we),
        .data_addr_i   (data_addr),
        .data_wdata_i  (data_wdata),
        .data_valid_o  (data_valid),
        .data_rdata_o  (data_rdata),
        .mem_request_o (mem_request),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_valid_i   (mem_valid),
        .mem_rdata_i   (mem_rdata),
        .busy_o        (busy),
        .timeout_err_o (timeout_err)
    );

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    // Model: the one transaction in flight, if any (owner 1 = data).
    bit          m_act   = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last  = 1'b0;
    bit          m_we    = 1'b0;
    logic [31:0] m_waddr = '0;
    logic [31:0] m_wdata = '0;
    int          m_issue = 0;

    // Expected outputs for the current cycle.
    bit          e_iv = 1'b0, e_dv = 1'b0, e_req = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [31:0] e_ird = '0, e_drd = '0;
    bit          after_rst = 1'b0;

    // Random-phase stimulus state.
    bit i_pend = 1'b0, d_pend = 1'b0;
    int mv_cyc = -1;
    int lat;

    task automatic chk1(input string nm, input logic a, input logic e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, a, e);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, a, e);
        end
    endtask

    task automatic finish_txn(input logic [31:0] v);
        if (m_owner) begin
            e_dv  = 1'b1;
            e_drd = v;
        end else begin
            e_iv  = 1'b1;
            e_ird = v;
        end
        m_act = 1'b0;
    endtask

    // Predict the outputs of cycle 'cyc' from the inputs held during cyc-1.
    task automatic advance();
        bit piv, pdv, ie, de;
        if (rst) begin
            m_act = 1'b0; m_last = 1'b0;
            e_iv = 1'b0; e_dv = 1'b0; e_req = 1'b0; e_busy = 1'b0; e_err = 1'b0;
            e_ird = '0; e_drd = '0;
            after_rst = 1'b1;
            return;
        end
        after_rst = 1'b0;
        piv  = e_iv;
        pdv  = e_dv;
        e_iv = 1'b0;
        e_dv = 1'b0;
        if (m_act) begin
            if (cyc - 1 > m_issue) begin
                if (mem_valid) begin
                    finish_txn(m_we ? 32'h0 : mem_rdata);
                end else if ((cyc - 1 - m_issue) == TO) begin
                    finish_txn(32'h0);
                    e_err = 1'b1;
                end
            end
        end else begin
            ie = inst_req && !piv;
            de = data_req && !pdv;
            if (ie || de) begin
                m_owner = (ie && de) ? !m_last : de;
                m_last  = m_owner;
                m_act   = 1'b1;
                m_issue = cyc;
                if (m_owner) begin
                    m_we    = data_we;
                    m_waddr = data_addr >> 2;
                    m_wdata = data_wdata;
                end else begin
                    m_we    = 1'b0;
                    m_waddr = inst_addr >> 2;
                end
            end
        end
        e_req  = m_act && (cyc == m_issue);
        e_busy = m_act;
    endtask

    task automatic compare();
        chk1("busy", busy, e_busy);
        chk1("mem_request", mem_request, e_req);
        chk1("inst_valid", inst_valid, e_iv);
        chk1("data_valid", data_valid, e_dv);
        chk32("inst_rdata", inst_rdata, e_ird);
        chk32("data_rdata", data_rdata, e_drd);
        chk1("timeout_err", timeout_err, e_err);
        if (e_busy) begin
            chk32("mem_addr", mem_addr, m_waddr);
            chk1("mem_we", mem_we, m_we);
            if (m_owner) chk32("mem_wdata", mem_wdata, m_wdata);
        end
        if (after_rst) begin
            chk32("rst_mem_addr", mem_addr, 32'h0);
            chk1("rst_mem_we", mem_we, 1'b0);
            chk32("rst_mem_wdata", mem_wdata, 32'h0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        advance();
        compare();
    endtask

    // Called in the issue cycle; returns in the completion-pulse cycle.
    // l == 0 means the memory never answers.
    task automatic serve(input int l, input logic [31:0] d);
        if (l == 0) begin
            repeat (TO + 1) tick();
        end else begin
            repeat (l) tick();
            mem_valid = 1'b1;
            mem_rdata = d;
            tick();
            mem_valid = 1'b0;
            mem_rdata = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        mem_valid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_err", timeout_err, 1'b0);
        rst = 1'b0;

        // Single fetch, latency 1.
        inst_req = 1'b1; inst_addr = 32'h0000_0010;
        tick();
        chk1("t1_req", mem_request, 1'b1);
        chk32("t1_addr", mem_addr, 32'h4);
        chk1("t1_we", mem_we, 1'b0);
        serve(1, 32'h00A0_0093);
        chk1("t1_valid", inst_valid, 1'b1);
        chk32("t1_rdata", inst_rdata, 32'h00A0_0093);
        inst_req = 1'b0;
        tick();

        // Both together after reset: data first, then alternation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0020; data_wdata = 32'hDEAD_BEEF;
        tick();
        chk1("t2_req", mem_request, 1'b1);
        chk32("t2_addr", mem_addr, 32'h8);
        chk1("t2_we", mem_we, 1'b1);
        chk32("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        serve(1, 32'h1234_5678);
        chk1("t2_dvalid", data_valid, 1'b1);
        chk32("t2_store_rdata", data_rdata, 32'h0);
        data_we = 1'b0; data_addr = 32'h0000_0024;
        tick();
        chk32("t2_inst_addr", mem_addr, 32'h40);
        chk1("t2_inst_we", mem_we, 1'b0);
        serve(2, 32'h1111_2222);
        chk32("t2_inst_rdata", inst_rdata, 32'h1111_2222);
        tick();
        chk32("t2_alt_data_addr", mem_addr, 32'h9);
        serve(1, 32'h3333_4444);
        chk32("t2_load_rdata", data_rdata, 32'h3333_4444);
        data_req = 1'b0;
        tick();
        chk32("t2_alt_inst_addr", mem_addr, 32'h40);
        serve(1, 32'h5555_6666);
        inst_req = 1'b0;
        tick();

        // Request held through its own completion pulse, latency 3.
        inst_req = 1'b1; inst_addr = 32'h0000_0200;
        tick();
        chk32("t3_addr", mem_addr, 32'h80);
        serve(3, 32'hA5A5_A5A5);
        chk1("t3_valid", inst_valid, 1'b1);
        tick();
        chk1("t3_no_dup", mem_request, 1'b0);
        chk1("t3_idle", busy, 1'b0);
        inst_req = 1'b0;
        tick();

        // Memory never responds.
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0300;
        tick();
        serve(0, 32'h0);
        chk1("t4_valid", data_valid, 1'b1);
        chk32("t4_rdata", data_rdata, 32'h0);
        chk1("t4_err", timeout_err, 1'b1);
        data_req = 1'b0;
        repeat (5) tick();
        chk1("t4_err_sticky", timeout_err, 1'b1);

        // Response in the exact timeout cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_0400;
        tick();
        serve(TO, 32'hCAFE_F00D);
        chk32("t6_rdata", inst_rdata, 32'hCAFE_F00D);
        chk1("t6_no_err", timeout_err, 1'b0);
        inst_req = 1'b0;
        tick();

        // Reset during WAIT, then a late response.
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0500; data_wdata = 32'h1;
        tick();
        tick();
        rst = 1'b1; data_req = 1'b0;
        tick();
        chk1("t5_busy", busy, 1'b0);
        rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_valid = 1'b0;
        tick();
        chk1("t5_no_pulse", data_valid, 1'b0);
        inst_req = 1'b1; inst_addr = 32'h0000_0600;
        tick();
        chk1("t5_next_req", mem_request, 1'b1);
        serve(1, 32'h0BAD_F00D);
        chk32("t5_next_rdata", inst_rdata, 32'h0BAD_F00D);
        inst_req = 1'b0;
        tick();

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (rst) begin
                mv_cyc = -1;
                i_pend = 1'b0; d_pend = 1'b0;
                inst_req = 1'b0; data_req = 1'b0;
            end else begin
                if (e_iv) begin
                    i_pend   = 1'b0;
                    inst_req = ($urandom_range(0, 1) == 1);
                end else if (!i_pend) begin
                    if ($urandom_range(0, 9) < 4) begin
                        i_pend = 1'b1; inst_req = 1'b1; inst_addr = $urandom;
                    end else begin
                        inst_req = 1'b0;
                    end
                end else if (m_act && !m_owner && inst_req && $urandom_range(0, 15) == 0) begin
                    inst_req = 1'b0;
                end
                if (e_dv) begin
                    d_pend   = 1'b0;
                    data_req = ($urandom_range(0, 1) == 1);
                end else if (!d_pend) begin
                    if ($urandom_range(0, 9) < 4) begin
                        d_pend = 1'b1; data_req = 1'b1; data_addr = $urandom;
                        data_we = ($urandom_range(0, 1) == 1); data_wdata = $urandom;
                    end else begin
                        data_req = 1'b0;
                    end
                end else if (m_act && m_owner && data_req && $urandom_range(0, 15) == 0) begin
                    data_req = 1'b0;
                end
            end
            if (e_req && !rst) begin
                lat = $urandom_range(0, 9);
                lat = (lat < 5) ? 1 : (lat < 7) ? 2 : (lat < 8) ? 3 : (lat < 9) ? TO : TO + 1;
                mv_cyc = (lat <= TO) ? cyc + lat : -1;
            end
            mem_valid = (cyc == mv_cyc);
            mem_rdata = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
